sudoku_mask_loader: RTL
=======================

Name: sudoku_mask_loader

Overview:
- Producer side of the 729-bit one-hot candidate mask consumed by the answer/partials logic.
- Accepts puzzle cells as a serial stream of 4-bit digit codes, one per handshake, in row-major order.
- Assembles the flat candidate mask and presents it with a valid/ack handshake.
- Sits between the puzzle input interface and the mask consumers of the sudoku check design.

Parameters:
- EMPTY_CODE, 0, digit code meaning "unknown cell"; sets all 9 candidate bits of that cell.
- GRID, 9, grid dimension; only 9 is supported, and any other value is an elaboration error.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  digit present on in_digit.
- in_ready  output  1  loader can accept a digit this cycle.
- in_digit  input  4  cell code: EMPTY_CODE = empty, 1..9 = given digit, anything else = invalid.
- in_first  input  1  qualifies the accepted digit as cell 0 (row 0, col 0); resynchronises the stream.
- puzzle_mask_bin  output  729  candidate mask; bit ((row*9+col)*9 + digit-1).
- mask_valid  output  1  complete 81-cell mask is held on puzzle_mask_bin.
- mask_ack  input  1  consumer has taken the mask.
- cell_count  output  7  number of cells accepted for the current puzzle, 0..81.
- bad_digit  output  1  sticky: at least one invalid code was accepted in the current puzzle.

Behaviour:
- Reset values: puzzle_mask_bin = 0, mask_valid = 0, cell_count = 0, bad_digit = 0, state = ACCEPT. in_ready is 1 in the first cycle after reset deassertion.
- States:
  - ACCEPT: in_ready = 1, mask_valid = 0.
  - FULL: in_ready = 0, mask_valid = 1.
- Accept condition: in_valid && in_ready.
- Target cell index:
  - in_first = 1 selects cell 0.
  - Otherwise the target is cell_count.
  - in_first takes priority even when cell_count = 80.
- Cell write per accept:
  - EMPTY_CODE writes 9'h1FF.
  - Digit d in 1..9 writes one-hot (1 << (d-1)).
  - Invalid code writes 9'h000 and sets bad_digit.
- Other cells are untouched by an accept.
- cell_count becomes target+1 on each accept.
- Accepting with in_first = 1 also clears bad_digit, except when that same digit is invalid; then bad_digit = 1.
- ACCEPT -> FULL on the accept that writes cell 80. mask_valid is high in the next cycle, giving 1-cycle latency from the last accept.
- FULL -> ACCEPT when mask_ack = 1. In the next cycle: cell_count = 0, bad_digit = 0, in_ready = 1. The mask register is held, not cleared.
- mask_ack in ACCEPT is ignored.
- in_valid in FULL is not accepted; the upstream must hold it.
- Reset mid-load discards all progress: state = ACCEPT, mask cleared.
- No combinational path from in_valid to in_ready. in_ready depends on state only.

Optional Feature:
- Macro: SUDOKU_LOADER_ROWCHK_EN.
- With the macro defined:
  - Adds output row_dup (1 bit, reset 0) and a 9-bit seen register for the current row.
  - The seen register clears when cell col 0 is accepted, including via in_first.
  - Accepting a given digit already marked in seen sets row_dup (sticky).
  - row_dup clears under the same conditions as bad_digit.
  - Empty and invalid codes are not tracked.
- Without the macro: no row_dup port, no seen register; all other behaviour identical.

Decomposition:
- Package sudoku_pkg:
  - SUDOKU_N = 9, SUDOKU_CELLS = 81, SUDOKU_MASK_W = 729, SUDOKU_DIGIT_W = 4.
  - Loader state enum {ACCEPT, FULL}.
  - Function cell_base(row, col) returning (row*9+col)*9.
- Sub-module sudoku_digit_onehot (combinational):
  - Input: 4-bit code and EMPTY_CODE parameter.
  - Outputs: 9-bit candidate vector and invalid flag.
  - Shared by the loader and future decoder blocks.
- The loader instantiates it once.

Test Plan:
- Stream 81 digits, all EMPTY_CODE, in_valid held high from cycle 0 -> accepted in cycles 0..80; mask_valid = 1 in cycle 81; puzzle_mask_bin = all ones; cell_count = 81; bad_digit = 0.
- Cell 0 = 5, cell 80 = 9, rest empty -> bits[8:0] = 9'h010 and bits[728:720] = 9'h100; all other cells 9'h1FF.
- Assert mask_ack in FULL -> next cycle in_ready = 1, cell_count = 0, mask_valid = 0; a stalled in_valid during FULL produces no accept.
- Send 40 digits, then digit 7 with in_first = 1 -> cell_count = 1; cell 0 = 9'h040; completion needs 80 more accepts.
- Code 4'hC at cell 10 -> cell 10 bits = 0 and bad_digit = 1 until the ack of that puzzle.
- With SUDOKU_LOADER_ROWCHK_EN: row 2 gets 3 at col 1 and 3 at col 6 -> row_dup = 1 from the cycle after the col-6 accept. The same 3s split across rows 2 and 3 -> row_dup stays 0.
- Assert rst in the middle of a load -> all outputs return to reset values in the next cycle.

Source files
------------

// File: rtl/sudoku_pkg.sv
// Shared constants, loader state encoding and mask addressing for the sudoku check design.
// Pure declarations; no logic, latency or backpressure of its own.
// Imported by the loader and the digit decoder.
package sudoku_pkg;

    localparam int SUDOKU_N       = 9;
    localparam int SUDOKU_CELLS   = 81;
    localparam int SUDOKU_MASK_W  = 729;
    localparam int SUDOKU_DIGIT_W = 4;

    typedef enum logic {
        ACCEPT = 1'b0,
        FULL   = 1'b1
    } loader_state_t;

    // LSB of the 9-bit candidate field for a cell in the flat mask.
    function automatic logic [9:0] cell_base(input logic [3:0] row, input logic [3:0] col);
        logic [9:0] idx;
        idx = {6'd0, row} * 10'd9 + {6'd0, col};
        return idx * 10'd9;
    endfunction

endpackage

// File: rtl/sudoku_digit_onehot.sv
// Decodes one cell code into its 9-bit candidate vector plus an invalid flag.
// Purely combinational, zero latency.
// No handshake; the caller qualifies the result with its own accept.
module sudoku_digit_onehot
    import sudoku_pkg::*;
#(
    parameter logic [SUDOKU_DIGIT_W-1:0] EMPTY_CODE = '0
) (
    input  logic [SUDOKU_DIGIT_W-1:0] code,
    output logic [SUDOKU_N-1:0]       cand,
    output logic                      invalid
);

    always_comb begin
        cand    = '0;
        invalid = 1'b0;
        // Empty is tested first so a nonzero EMPTY_CODE overrides a digit value.
        if (code == EMPTY_CODE) begin
            cand = '1;
        end else if (code >= 4'd1 && code <= 4'd9) begin
            cand = 9'h001 << (code - 4'd1);
        end else begin
            invalid = 1'b1;
        end
    end

endmodule

// File: rtl/sudoku_mask_loader.sv
// Serial digit stream to flat 729-bit candidate mask; optional row-duplicate check under SUDOKU_LOADER_ROWCHK_EN.
// Latency: mask_valid rises the cycle after the accept that writes cell 80.
// Backpressure: in_ready drops (state only) while a full mask waits for mask_ack.
module sudoku_mask_loader
    import sudoku_pkg::*;
#(
    parameter logic [SUDOKU_DIGIT_W-1:0] EMPTY_CODE = '0,
    parameter int                        GRID       = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SUDOKU_DIGIT_W-1:0] in_digit,
    input  logic                      in_first,
    output logic [SUDOKU_MASK_W-1:0]  puzzle_mask_bin,
    output logic                      mask_valid,
    input  logic                      mask_ack,
    output logic [6:0]                cell_count,
    output logic                      bad_digit
`ifdef SUDOKU_LOADER_ROWCHK_EN
    ,
    output logic                      row_dup
`endif
);

    generate
        if (GRID != SUDOKU_N) begin : g_grid_chk
            $error("sudoku_mask_loader: only GRID = 9 is supported");
        end
    endgenerate

    loader_state_t state_q, state_d;

    logic [SUDOKU_MASK_W-1:0] mask_q;
    logic [6:0]               count_q;
    logic                     bad_q;
    logic [3:0]               row_q, col_q;

    logic [3:0]          trow, tcol;
    logic [6:0]          target;
    logic                accept;
    logic                last_cell;
    logic [SUDOKU_N-1:0] cand;
    logic                invalid;

    sudoku_digit_onehot #(
        .EMPTY_CODE (EMPTY_CODE)
    ) u_onehot (
        .code    (in_digit),
        .cand    (cand),
        .invalid (invalid)
    );

    // Row/col are tracked alongside the count so addressing needs no divider.
    assign target    = in_first ? 7'd0 : count_q;
    assign trow      = in_first ? 4'd0 : row_q;
    assign tcol      = in_first ? 4'd0 : col_q;
    assign accept    = in_valid && (state_q == ACCEPT);
    assign last_cell = (target == 7'(SUDOKU_CELLS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCEPT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        mask_valid = 1'b0;
        unique case (state_q)
            ACCEPT: begin
                in_ready = 1'b1;
                if (accept && last_cell) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                mask_valid = 1'b1;
                if (mask_ack) begin
                    state_d = ACCEPT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q  <= '0;
            count_q <= '0;
            bad_q   <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
        end else if (state_q == FULL) begin
            // The mask itself is held after the ack; only progress is cleared.
            if (mask_ack) begin
                count_q <= '0;
                bad_q   <= 1'b0;
                row_q   <= '0;
                col_q   <= '0;
            end
        end else if (accept) begin
            mask_q[cell_base(trow, tcol) +: SUDOKU_N] <= cand;
            count_q <= target + 7'd1;
            bad_q   <= (in_first ? 1'b0 : bad_q) | invalid;
            if (tcol == 4'd8) begin
                col_q <= '0;
                row_q <= trow + 4'd1;
            end else begin
                col_q <= tcol + 4'd1;
                row_q <= trow;
            end
        end
    end

    assign puzzle_mask_bin = mask_q;
    assign cell_count      = count_q;
    assign bad_digit       = bad_q;

`ifdef SUDOKU_LOADER_ROWCHK_EN
    logic [SUDOKU_N-1:0] seen_q;
    logic [SUDOKU_N-1:0] seen_base;
    logic                row_dup_q;
    logic                is_given;

    assign is_given  = !invalid && (in_digit != EMPTY_CODE);
    assign seen_base = (tcol == 4'd0) ? '0 : seen_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q    <= '0;
            row_dup_q <= 1'b0;
        end else if (state_q == FULL) begin
            if (mask_ack) begin
                row_dup_q <= 1'b0;
            end
        end else if (accept) begin
            seen_q    <= is_given ? (seen_base | cand) : seen_base;
            row_dup_q <= (in_first ? 1'b0 : row_dup_q) | (is_given && |(seen_base & cand));
        end
    end

    assign row_dup = row_dup_q;
`endif

endmodule
